// File: rtl/prbs_pkg.sv
// Shared PRBS constants and checker state type for the x^65 + x^18 + 1, 16-bit word stream.
// The generator side imports the same constants.
package prbs_pkg;

    localparam int unsigned PRBS_LEN  = 65;
    localparam int unsigned PRBS_TAP  = 18;
    localparam int unsigned PRBS_WORD = 16;

    typedef enum logic {
        SEED,
        CHECK
    } prbs_state_e;

endpackage

// File: rtl/popcount16.sv
// 16-bit combinational population count with a 5-bit result (0..16).
module popcount16 (
    input  logic [15:0] din,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(din[i]);
        end
    end

endmodule

// File: rtl/prbs65_16_chk.sv
// PRBS65 16-bit word checker: self-seeds from the received stream, then predicts and compares.
// Optional feature PRBS_CHK_RESEED_EN: re-seed after BAD_RUN consecutive errored words.
module prbs65_16_chk
    import prbs_pkg::*;
#(
    parameter int unsigned BAD_RUN = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [15:0]      din,
    input  logic             din_vld,
    output logic             locked,
    output logic             err_pulse,
    output logic [4:0]       err_bits,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_word_cnt,
    output logic [CNT_W-1:0] err_bit_cnt
);

    prbs_state_e         state_q, state_d;
    logic [PRBS_LEN:1]   s_q, s_d;
    logic [6:0]          seed_cnt_q, seed_cnt_d;
    logic                err_pulse_q, err_pulse_d;
    logic [4:0]          err_bits_q, err_bits_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    err_word_cnt_q, err_word_cnt_d;
    logic [CNT_W-1:0]    err_bit_cnt_q, err_bit_cnt_d;

    logic                   fb;
    logic [PRBS_LEN:1]      seed_shift;
    logic [PRBS_WORD-1:0]   expected;
    logic [PRBS_WORD-1:0]   mism;
    logic [4:0]             mism_bits;

`ifdef PRBS_CHK_RESEED_EN
    localparam int unsigned RUN_W = $clog2(BAD_RUN + 1);
    logic [RUN_W-1:0] run_q, run_d;
`endif

    // Saturating add: the carry out of a widened sum clamps to all-ones, covering partial adds.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W + 1)'(b);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign fb         = s_q[PRBS_LEN] ^ s_q[PRBS_TAP];
    assign seed_shift = {s_q[PRBS_LEN-1:1], din[0]};
    assign expected   = {s_q[PRBS_WORD-1:1], fb};
    assign mism       = din ^ expected;

    popcount16 u_popcount16 (
        .din (mism),
        .cnt (mism_bits)
    );

    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        seed_cnt_d     = seed_cnt_q;
        err_pulse_d    = 1'b0;
        err_bits_d     = err_bits_q;
        word_cnt_d     = word_cnt_q;
        err_word_cnt_d = err_word_cnt_q;
        err_bit_cnt_d  = err_bit_cnt_q;
`ifdef PRBS_CHK_RESEED_EN
        run_d          = run_q;
`endif
        if (clr) begin
            state_d        = SEED;
            s_d            = '0;
            seed_cnt_d     = 7'd0;
            err_bits_d     = 5'd0;
            word_cnt_d     = '0;
            err_word_cnt_d = '0;
            err_bit_cnt_d  = '0;
`ifdef PRBS_CHK_RESEED_EN
            run_d          = '0;
`endif
        end else begin
            unique case (state_q)
                SEED: begin
                    err_bits_d = 5'd0;
                    if (din_vld) begin
                        s_d = seed_shift;
                        if (seed_cnt_q == 7'(PRBS_LEN - 1)) begin
                            seed_cnt_d = 7'd0;
                            // An all-zero seed would lock the LFSR in its stuck state.
                            if (|seed_shift) state_d = CHECK;
                        end else begin
                            seed_cnt_d = seed_cnt_q + 7'd1;
                        end
                    end
                end
                CHECK: begin
                    if (din_vld) begin
                        // Prediction runs on its own feedback so line errors never propagate.
                        s_d         = {s_q[PRBS_LEN-1:1], fb};
                        err_pulse_d = |mism;
                        err_bits_d  = mism_bits;
                        word_cnt_d  = sat_add(word_cnt_q, 5'd1);
                        if (|mism) begin
                            err_word_cnt_d = sat_add(err_word_cnt_q, 5'd1);
                            err_bit_cnt_d  = sat_add(err_bit_cnt_q, mism_bits);
                        end
`ifdef PRBS_CHK_RESEED_EN
                        if (|mism) begin
                            if (run_q == RUN_W'(BAD_RUN - 1)) begin
                                state_d    = SEED;
                                seed_cnt_d = 7'd0;
                                run_d      = '0;
                            end else begin
                                run_d = run_q + 1'b1;
                            end
                        end else begin
                            run_d = '0;
                        end
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= SEED;
            s_q            <= '0;
            seed_cnt_q     <= 7'd0;
            err_pulse_q    <= 1'b0;
            err_bits_q     <= 5'd0;
            word_cnt_q     <= '0;
            err_word_cnt_q <= '0;
            err_bit_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            s_q            <= s_d;
            seed_cnt_q     <= seed_cnt_d;
            err_pulse_q    <= err_pulse_d;
            err_bits_q     <= err_bits_d;
            word_cnt_q     <= word_cnt_d;
            err_word_cnt_q <= err_word_cnt_d;
            err_bit_cnt_q  <= err_bit_cnt_d;
        end
    end

`ifdef PRBS_CHK_RESEED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_q <= '0;
        else     run_q <= run_d;
    end
`endif

    assign locked       = (state_q == CHECK);
    assign err_pulse    = err_pulse_q;
    assign err_bits     = err_bits_q;
    assign word_cnt     = word_cnt_q;
    assign err_word_cnt = err_word_cnt_q;
    assign err_bit_cnt  = err_bit_cnt_q;

endmodule

// File: tb/tb_prbs65_16_chk.sv
// Directed bench for prbs65_16_chk: a 32-bit-counter instance plus a 6-bit-counter instance
// sharing the same stimulus, the latter exposing counter saturation quickly.
module tb_prbs65_16_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] din = 16'h0;
    logic        din_vld = 1'b0;

    logic        locked, err_pulse;
    logic [4:0]  err_bits;
    logic [31:0] word_cnt, err_word_cnt, err_bit_cnt;

    logic        s_locked, s_err_pulse;
    logic [4:0]  s_err_bits;
    logic [5:0]  s_word_cnt, s_err_word_cnt, s_err_bit_cnt;

    int checks = 0;
    int errors = 0;
    int gap_pulses = 0;

    logic [65:1] g;

    always #5 clk = ~clk;

    prbs65_16_chk #(.BAD_RUN(4), .CNT_W(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .din          (din),
        .din_vld      (din_vld),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_bits     (err_bits),
        .word_cnt     (word_cnt),
        .err_word_cnt (err_word_cnt),
        .err_bit_cnt  (err_bit_cnt)
    );

    prbs65_16_chk #(.BAD_RUN(4), .CNT_W(6)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .din          (din),
        .din_vld      (din_vld),
        .locked       (s_locked),
        .err_pulse    (s_err_pulse),
        .err_bits     (s_err_bits),
        .word_cnt     (s_word_cnt),
        .err_word_cnt (s_err_word_cnt),
        .err_bit_cnt  (s_err_bit_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word for one clock edge; returns 1 time unit after that edge.
    task automatic send_word(input logic [15:0] w);
        din     = w;
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
    endtask

    // Transmitter model: current word is the low 16 bits of the LFSR, then one shift.
    task automatic send_gen(input logic [15:0] flip);
        send_word(g[16:1] ^ flip);
        g = {g[64:1], g[65] ^ g[18]};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (err_pulse) gap_pulses++;
        end
    endtask

    initial begin
        g = 65'h1_2345_6789_ABCD_EF01;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_locked", locked, 0);
        check_eq("rst_err_pulse", err_pulse, 0);
        check_eq("rst_err_bits", err_bits, 0);
        check_eq("rst_word_cnt", word_cnt, 0);
        check_eq("rst_err_word_cnt", err_word_cnt, 0);
        check_eq("rst_err_bit_cnt", err_bit_cnt, 0);
        rst = 1'b0;
        idle(1);

        // All-zero stream must not lock.
        for (int i = 0; i < 65; i++) send_word(16'h0);
        check_eq("zero_seed_locked", locked, 0);

        // Valid stream: lock exactly after the 65th beat.
        for (int i = 0; i < 64; i++) send_gen(16'h0);
        check_eq("seed64_locked", locked, 0);
        send_gen(16'h0);
        check_eq("seed65_locked", locked, 1);
        check_eq("seed65_word_cnt", word_cnt, 0);

        for (int i = 0; i < 1000; i++) send_gen(16'h0);
        check_eq("run_word_cnt", word_cnt, 1000);
        check_eq("run_err_word_cnt", err_word_cnt, 0);
        check_eq("run_err_bit_cnt", err_bit_cnt, 0);
        check_eq("sat_word_cnt", s_word_cnt, 63);

        // Two flipped bits on a single word.
        send_gen(16'h1008);
        check_eq("inj_err_pulse", err_pulse, 1);
        check_eq("inj_err_bits", err_bits, 2);
        check_eq("inj_err_word_cnt", err_word_cnt, 1);
        check_eq("inj_err_bit_cnt", err_bit_cnt, 2);
        idle(1);
        check_eq("gap_err_pulse", err_pulse, 0);
        check_eq("gap_err_bits_hold", err_bits, 2);
        send_gen(16'h0);
        check_eq("clean_err_pulse", err_pulse, 0);
        check_eq("clean_err_bits", err_bits, 0);
        for (int i = 0; i < 10; i++) send_gen(16'h0);
        check_eq("noprop_err_word_cnt", err_word_cnt, 1);
        check_eq("noprop_word_cnt", word_cnt, 1012);

        // clr coincident with a valid beat: beat discarded, everything cleared.
        clr = 1'b1;
        send_gen(16'h0);
        clr = 1'b0;
        check_eq("clr_locked", locked, 0);
        check_eq("clr_word_cnt", word_cnt, 0);
        check_eq("clr_err_word_cnt", err_word_cnt, 0);
        check_eq("clr_err_bit_cnt", err_bit_cnt, 0);
        check_eq("clr_err_bits", err_bits, 0);

        // Gapped stream: reseed and run 1000 words with random idle gaps.
        gap_pulses = 0;
        for (int i = 0; i < 65; i++) begin
            send_gen(16'h0);
            idle($urandom_range(0, 1));
        end
        check_eq("gapped_locked", locked, 1);
        for (int i = 0; i < 1000; i++) begin
            send_gen(16'h0);
            idle($urandom_range(0, 1));
        end
        check_eq("gapped_word_cnt", word_cnt, 1000);
        check_eq("gapped_err_word_cnt", err_word_cnt, 0);
        check_eq("gapped_err_bit_cnt", err_bit_cnt, 0);
        check_eq("gapped_pulses", gap_pulses, 0);

        // Four fully inverted words: 64 bit errors, saturating the 6-bit counter at 63.
        for (int i = 0; i < 4; i++) send_gen(16'hFFFF);
        check_eq("burst_err_bits", err_bits, 16);
        check_eq("burst_err_word_cnt", err_word_cnt, 4);
        check_eq("burst_err_bit_cnt", err_bit_cnt, 64);
        check_eq("sat_err_bit_cnt", s_err_bit_cnt, 63);
        check_eq("sat_err_word_cnt", s_err_word_cnt, 4);
`ifdef PRBS_CHK_RESEED_EN
        check_eq("reseed_locked_fall", locked, 0);
        for (int i = 0; i < 64; i++) send_gen(16'h0);
        check_eq("reseed64_locked", locked, 0);
        send_gen(16'h0);
        check_eq("reseed65_locked", locked, 1);
        check_eq("reseed_err_word_hold", err_word_cnt, 4);
        check_eq("reseed_word_hold", word_cnt, 1004);
`else
        check_eq("noreseed_locked", locked, 1);
        for (int i = 0; i < 65; i++) send_gen(16'h0);
        check_eq("noreseed_err_word_cnt", err_word_cnt, 4);
        check_eq("noreseed_word_cnt", word_cnt, 1069);
`endif

        // Asynchronous reset mid-operation.
        din     = g[16:1];
        din_vld = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_locked", locked, 0);
        check_eq("arst_word_cnt", word_cnt, 0);
        check_eq("arst_err_bit_cnt", err_bit_cnt, 0);
        din_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs65_16_chk.md
# prbs65_16_chk

Receive-side checker for the 65-bit PRBS (x^65 + x^18 + 1) 16-bit word stream used in the rad4test link tests. The block self-seeds from the incoming words, then predicts and compares every subsequent word, counting errored words and errored bits. It sits at the far end of the fibre/cable path, facing the PRBS word generator on the transmit board, and reports lock and error counts to the slow-control register map.

## Interface
- BAD_RUN, 4: consecutive errored words that force re-seed (used only with the re-seed feature).
- CNT_W, 32: width of all event counters.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of counters and forced re-seed.
- din  in  16  received PRBS word.
- din_vld  in  1  din holds a new word advanced exactly one LFSR shift from the previous valid word.
- locked  out  1  high while in CHECK.
- err_pulse  out  1  one-cycle pulse: last checked word mismatched.
- err_bits  out  5  mismatching bit count of last checked word (0..16).
- word_cnt  out  CNT_W  words checked while locked, saturating.
- err_word_cnt  out  CNT_W  errored words, saturating.
- err_bit_cnt  out  CNT_W  errored bits, saturating.

## Operation
- Shadow register s[65:1]; state machine SEED / CHECK.
- SEED: each din_vld shifts s <= {s[64:1], din[0]}, seed_cnt increments (7 bits, 0..64). On the 65th beat, if the new s is nonzero → CHECK, seed_cnt <= 0; if s is all-zero → stay in SEED, seed_cnt <= 0 (illegal stuck state).
- After seeding, s[16:1] equals the last received word, and s equals the transmitter LFSR state.
- CHECK: expected = {s[15:1], s[65]^s[18]}. On din_vld, s <= {s[64:1], s[65]^s[18]}. s is driven only by its own feedback, never by din, so line errors do not propagate. mism = din ^ expected; err_bits = popcount(mism); err_pulse = |mism.
- Counters in CHECK on din_vld: word_cnt +1; on mismatch err_word_cnt +1, err_bit_cnt += err_bits. All counters saturate at all-ones and never wrap, including a partial add near the top.
- No counting in SEED; err_pulse is 0 and err_bits is 0 there.
- din_vld low: s, state, and counters hold; err_pulse is 0 and err_bits holds its last value.
- clr (priority over din_vld in the same cycle; that beat is discarded): counters, s, seed_cnt, err_bits ← 0, state ← SEED.
- rst mid-operation: immediate return to reset values with no pending update.

## Timing
- Reset values: locked=0, err_pulse=0, err_bits=0, all counters 0, s=0, state SEED.
- locked rises the cycle after the 65th seeding din_vld edge.
- The first checked word is the 66th valid word.
- err_pulse, err_bits, and the counters update 1 cycle after the din_vld clock edge (registered). There is no combinational path from din to the outputs.
- Back-to-back din_vld at full clock rate is supported. No backpressure.

## Configuration
- PRBS_CHK_RESEED_EN defined: a run counter counts consecutive errored words and clears on any good word. When it reaches BAD_RUN, the next cycle goes to SEED: locked ← 0 and seed_cnt ← 0, while counters hold their values. The BAD_RUN-th errored word is still counted.
- Not defined: once in CHECK, the block stays locked until rst or clr. The run counter and BAD_RUN logic are absent.

## Structure
- Shared package prbs_pkg: PRBS_LEN=65, PRBS_TAP=18, PRBS_WORD=16, and the state enum {SEED, CHECK}. The generator side imports the same constants.
- One sub-module, popcount16: 16-bit combinational population count with a 5-bit result.

## Test plan
- Generator seeded 65'h1_2345_6789_ABCD_EF01 streaming continuously → locked rises 1 cycle after the 65th din_vld; 1000 further words give word_cnt=1000, err_word_cnt=0, err_bit_cnt=0.
- Once locked, flip din bits [3] and [12] on a single word → err_pulse for one cycle, err_bits=2, err_word_cnt=1, err_bit_cnt=2. Following words are clean, which shows no error propagation.
- din_vld gapped at random (50% duty) → same counts as the continuous case; err_pulse never asserts during gaps.
- All-zero stream for 65 beats → locked stays 0; then a valid stream → lock after 65 further beats.
- With PRBS_CHK_RESEED_EN and BAD_RUN=4, invert 4 consecutive words → err_word_cnt=4, locked falls, then relocks 65 valid words later. Without the macro, the same stimulus leaves locked=1.
- clr asserted coincident with din_vld while locked → next cycle all counters 0 and locked=0; that beat is not counted. Counters preloaded near all-ones via a forced/long run saturate at 2^CNT_W-1.
